ifu_prefetch: RTL and testbench

Next-generation instruction fetch unit. It fetches sequential instructions ahead of decode over an AXI4-Lite read channel, keeping up to MAX_OUTSTANDING requests in flight. Fetched words are buffered in a DEPTH-entry FIFO and handed to the IDU over a valid/ready handshake, together with their PC and a fault flag. Redirects from EXU (branch, jump, trap) flush the buffer and discard responses already in flight.

---
 rtl/ifu_pkg.sv | 20 ++
 rtl/ifu_prefetch_fifo.sv | 54 +++++
 rtl/ifu_prefetch.sv | 143 ++++++++++++++
 tb/tb_ifu_prefetch.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package ifu_pkg;

  localparam int unsigned IFU_ADDR_W = 32;
  localparam int unsigned IFU_DATA_W = 32;
  localparam int unsigned INST_BYTES = 4;
  localparam logic [1:0]  RESP_OKAY  = 2'b00;

  typedef struct packed {
    logic [IFU_DATA_W-1:0] inst;
    logic [IFU_ADDR_W-1:0] pc;
    logic                  fault;
  } fetch_entry_t;

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_PEND = 1'b1
  } ar_state_t;

endpackage

// File: rtl/ifu_prefetch_fifo.sv
// Synchronous FIFO with flush; head entry is visible combinationally on dout.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage carries no reset; consumers gate the head with empty.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifu_prefetch.sv
// Sequential instruction prefetcher: AXI4-Lite reads into a small FIFO toward decode.
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int unsigned      ADDR_W          = IFU_ADDR_W,
  parameter int unsigned      DATA_W          = IFU_DATA_W,
  parameter int unsigned      DEPTH           = 4,
  parameter int unsigned      MAX_OUTSTANDING = 2,
  parameter logic [ADDR_W-1:0] RESET_PC       = ADDR_W'(32'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned DROP_W = $clog2(MAX_OUTSTANDING + 2);
  localparam int unsigned SUM_W  = CNT_W + OUT_W;
  localparam int unsigned ENT_W  = $bits(fetch_entry_t);

  ar_state_t         ar_state;
  ar_state_t         ar_state_d;
  logic              launch;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [ADDR_W-1:0] redir_pc;
  logic [OUT_W-1:0]  outstanding;
  logic [OUT_W-1:0]  outstanding_nx;
  logic [DROP_W-1:0] drop_cnt;
  logic [SUM_W-1:0]  credit_used;
  logic              issue_ok;
  logic              ar_hs;
  logic              r_hs;
  logic              keep;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic [ENT_W-1:0]  fifo_dout;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign arvalid  = (ar_state == AR_PEND);
  assign ar_hs    = arvalid && arready;
  assign r_hs     = rvalid && rready;
  assign redir_pc = redirect_pc & ~ADDR_W'(3);

  // Every accepted response must find a free FIFO slot when it returns.
  assign credit_used    = SUM_W'(outstanding) + SUM_W'(fifo_count) + SUM_W'(arvalid);
  assign issue_ok       = (credit_used < SUM_W'(DEPTH)) &&
                          (outstanding < OUT_W'(MAX_OUTSTANDING)) && !fifo_full;
  assign outstanding_nx = outstanding + OUT_W'(ar_hs) - OUT_W'(r_hs);
  assign keep           = r_hs && (drop_cnt == '0) && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) ar_state <= AR_IDLE;
    else     ar_state <= ar_state_d;
  end

  // No launch on a redirect cycle: fetch_pc is being replaced that same edge.
  always_comb begin
    ar_state_d = ar_state;
    launch     = 1'b0;
    case (ar_state)
      AR_IDLE: begin
        if (issue_ok && !redirect_valid) begin
          ar_state_d = AR_PEND;
          launch     = 1'b1;
        end
      end
      AR_PEND: begin
        if (arready) ar_state_d = AR_IDLE;
      end
      default: ar_state_d = AR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      araddr      <= '0;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      rready      <= 1'b0;
    end else begin
      rready      <= 1'b1;
      outstanding <= outstanding_nx;
      if (launch) araddr <= fetch_pc;

      if (redirect_valid) fetch_pc <= redir_pc;
      else if (launch)    fetch_pc <= fetch_pc + ADDR_W'(INST_BYTES);

      if (redirect_valid) resp_pc <= redir_pc;
      else if (keep)      resp_pc <= resp_pc + ADDR_W'(INST_BYTES);

      // Everything still in flight after this edge, incl. a pending AR, is stale.
      if (redirect_valid)
        drop_cnt <= DROP_W'(outstanding_nx) + DROP_W'(arvalid && !arready);
      else if (r_hs && (drop_cnt != '0))
        drop_cnt <= drop_cnt - DROP_W'(1);
    end
  end

  assign push_entry = '{inst: rdata, pc: resp_pc, fault: (rresp != RESP_OKAY)};
  assign head       = fifo_dout;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (keep),
    .pop   (inst_valid && inst_ready),
    .flush (redirect_valid),
    .din   (push_entry),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? head.inst  : '0;
  assign inst_pc    = inst_valid ? head.pc    : '0;
  assign inst_fault = inst_valid ? head.fault : 1'b0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed and randomized checks of ifu_prefetch against an in-order fetch-stream model.
module tb_ifu_prefetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;

  ifu_prefetch #(
    .ADDR_W          (32),
    .DATA_W          (32),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (RESET_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .araddr         (araddr),
    .arvalid        (arvalid),
    .arready        (arready),
    .rdata          (rdata),
    .rresp          (rresp),
    .rvalid         (rvalid),
    .rready         (rready),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;

  int          errors;
  int          checks;
  int          cyc;
  int          ar_cnt, r_cnt, pop_cnt, r_limit;
  int          ar_mode, lat_max, ir_mode;
  bit          rand_redir;
  bit          redir_arm, redir_coincide, redir_fired;
  logic [31:0] redir_tgt;
  logic [31:0] exp_pc, exp_ar;
  bit          skip_stale;
  bit          prev_ar_stall;
  logic [31:0] prev_araddr;
  rsp_t        sq[$];
  logic [31:0] ar_log[$];
  logic [31:0] pc_log[$];
  logic        flt_log[$];
  int          r0, pf, idx;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic fault_fn(input logic [31:0] a);
    return (a == 32'h8000_0004) || (a[7:2] == 6'h2B);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs at negedge, account for the handshakes of the coming edge.
  task automatic tick();
    if (prev_ar_stall) begin
      chk("ar_hold_valid", 32'(arvalid), 32'd1);
      chk("ar_hold_addr", araddr, prev_araddr);
    end
    case (ar_mode)
      0:       arready = 1'b1;
      1:       arready = ((ar_cnt - r_cnt) == 0);
      default: arready = 1'($urandom_range(0, 1));
    endcase
    if (sq.size() > 0 && sq[0].due <= cyc && r_cnt < r_limit) begin
      rvalid = 1'b1;
      rdata  = mem_fn(sq[0].addr);
      rresp  = fault_fn(sq[0].addr) ? 2'b10 : 2'b00;
    end else begin
      rvalid = 1'b0;
      rdata  = '0;
      rresp  = '0;
    end
    inst_ready     = (ir_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(ir_mode);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (redir_arm && (!redir_coincide || (rvalid && rready && inst_valid && inst_ready))) begin
      redirect_valid = 1'b1;
      redirect_pc    = redir_tgt;
      redir_arm      = 1'b0;
      redir_fired    = 1'b1;
    end else if (rand_redir && $urandom_range(0, 24) == 0) begin
      redirect_valid = 1'b1;
      redirect_pc    = $urandom;
    end

    if (inst_valid && inst_ready) begin
      chk("pop_pc", inst_pc, exp_pc);
      chk("pop_inst", inst, mem_fn(exp_pc));
      chk("pop_fault", 32'(inst_fault), 32'(fault_fn(exp_pc)));
      pc_log.push_back(inst_pc);
      flt_log.push_back(inst_fault);
      exp_pc = exp_pc + 32'd4;
      pop_cnt++;
    end
    if (arvalid && arready) begin
      if (skip_stale) skip_stale = 1'b0;
      else begin
        chk("ar_addr", araddr, exp_ar);
        exp_ar = exp_ar + 32'd4;
      end
      sq.push_back('{addr: araddr, due: cyc + int'($urandom_range(1, lat_max))});
      ar_log.push_back(araddr);
      ar_cnt++;
    end
    if (rvalid && rready) begin
      void'(sq.pop_front());
      r_cnt++;
    end
    if (redirect_valid) begin
      exp_pc     = redirect_pc & ~32'd3;
      exp_ar     = redirect_pc & ~32'd3;
      skip_stale = arvalid && !arready;
    end
    prev_ar_stall = arvalid && !arready;
    prev_araddr   = araddr;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
    inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_fault", 32'(inst_fault), 32'd0);
    sq.delete(); ar_log.delete(); pc_log.delete(); flt_log.delete();
    ar_cnt = 0; r_cnt = 0; pop_cnt = 0; r_limit = 1 << 30;
    exp_pc = RESET_PC; exp_ar = RESET_PC;
    skip_stale = 1'b0; prev_ar_stall = 1'b0;
    redir_arm = 1'b0; redir_fired = 1'b0; rand_redir = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    errors = 0; checks = 0; cyc = 0;
    ar_mode = 0; lat_max = 1; ir_mode = 1;
    redir_coincide = 1'b0; redir_tgt = '0;

    // Streaming fetch with a fault on the second word
    do_reset(3);
    repeat (30) tick();
    chk("t1_ar_count", 32'(ar_log.size() >= 3), 32'd1);
    chk("t1_ar0", ar_log[0], 32'h8000_0000);
    chk("t1_ar1", ar_log[1], 32'h8000_0004);
    chk("t1_ar2", ar_log[2], 32'h8000_0008);
    chk("t1_pc0", pc_log[0], 32'h8000_0000);
    chk("t1_pc2", pc_log[2], 32'h8000_0008);
    chk("t1_flt0", 32'(flt_log[0]), 32'd0);
    chk("t1_flt1", 32'(flt_log[1]), 32'd1);
    chk("t1_flt2", 32'(flt_log[2]), 32'd0);

    // Decode stalled: credit caps accepted reads at FIFO depth
    ir_mode = 0;
    do_reset(2);
    repeat (20) tick();
    chk("t2_ar_cnt", 32'(ar_cnt), 32'd4);
    chk("t2_arvalid", 32'(arvalid), 32'd0);
    chk("t2_inst_valid", 32'(inst_valid), 32'd1);
    chk("t2_head_pc", inst_pc, 32'h8000_0000);
    ir_mode = 1;
    for (int i = 0; i < 40 && (pop_cnt < 4 || ar_cnt < 5); i++) tick();
    chk("t2_drained", 32'(pop_cnt >= 4), 32'd1);
    chk("t2_pc3", pc_log[3], 32'h8000_000C);
    chk("t2_resume", ar_log[4], 32'h8000_0010);

    // Redirect with one read in flight, one AR pending, and a buffered entry
    ir_mode = 0; ar_mode = 1;
    do_reset(2);
    r_limit = 1;
    for (int i = 0; i < 40 && !(arvalid && (ar_cnt - r_cnt) == 1 && inst_valid); i++) tick();
    chk("t3_setup", 32'(arvalid && (ar_cnt - r_cnt) == 1 && inst_valid), 32'd1);
    redir_arm = 1'b1; redir_coincide = 1'b0; redir_tgt = 32'h8000_1002;
    tick();
    chk("t3_fired", 32'(redir_fired), 32'd1);
    chk("t3_flushed", 32'(inst_valid), 32'd0);
    r_limit = 1 << 30; ar_mode = 0; ir_mode = 1;
    r0 = r_cnt;
    for (int i = 0; i < 40 && !inst_valid; i++) tick();
    chk("t3_resp_until_valid", 32'(r_cnt - r0), 32'd3);
    chk("t3_first_pc", inst_pc, 32'h8000_1000);
    repeat (10) tick();

    // Redirect coinciding with an R handshake and an IDU pop
    ir_mode = 0;
    do_reset(2);
    repeat (8) tick();
    ir_mode = 1;
    redir_arm = 1'b1; redir_coincide = 1'b1; redir_tgt = 32'h8000_2000;
    for (int i = 0; i < 30 && redir_arm; i++) tick();
    chk("t4_fired", 32'(redir_fired), 32'd1);
    chk("t4_flushed", 32'(inst_valid), 32'd0);
    pf = pop_cnt;
    for (int i = 0; i < 30 && pop_cnt == pf; i++) tick();
    idx = pc_log.size() - 1;
    chk("t4_first_pc", pc_log[idx], 32'h8000_2000);

    // Reset with two reads outstanding
    do_reset(2);
    r_limit = 0;
    for (int i = 0; i < 20 && (ar_cnt - r_cnt) < 2; i++) tick();
    chk("t5_two_out", 32'(ar_cnt - r_cnt), 32'd2);
    do_reset(1);
    for (int i = 0; i < 20 && ar_cnt < 1; i++) tick();
    chk("t5_first_ar", ar_log[0], 32'h8000_0000);

    // Randomized backpressure, latency and redirects
    ar_mode = 2; lat_max = 3; ir_mode = 2;
    do_reset(2);
    rand_redir = 1'b1;
    repeat (600) tick();
    chk("t6_progress", 32'(pop_cnt > 20), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
